// File: rtl/pipe_chain.sv
// pipe_chain: generic in-order pipeline register chain with a stall/flush
// controller, valid tracking, a youngest-match forwarding lookup and a
// saturating stall-cycle counter.
// Optional feature macro: PIPE_CHAIN_FWD_EN (forwarding lookup comparators).
// Without the macro, lookup_hit/lookup_data are tied to zero.
module pipe_chain #(
    parameter int STAGES = 5,
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int CW     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [AW-1:0]             in_waddr,
    input  logic                      in_wen,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall_req,
    input  logic                      flush,
    output logic [STAGES-1:0]         stall_o,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [AW-1:0]             out_waddr,
    output logic                      out_wen,
    input  logic [AW-1:0]             lookup_addr,
    output logic                      lookup_hit,
    output logic [WIDTH-1:0]          lookup_data,
    input  logic                      cnt_clr,
    output logic [CW-1:0]             stall_cnt
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] wen_q,   wen_d;
    logic [AW-1:0]     waddr_q [STAGES];
    logic [AW-1:0]     waddr_d [STAGES];
    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [WIDTH-1:0]  data_d  [STAGES];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [STAGES-1:0] stall_vec;

    // A stage freezes when it or any older stage cannot advance.
    always_comb begin
        stall_vec = '0;
        for (int k = 0; k < STAGES; k++) begin
            stall_vec[k] = |(stall_req >> k);
        end
    end

    // Per-stage next state: flush, then hold, then bubble, then advance.
    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        data_d  = data_q;

        if (flush || !in_valid) begin
            if (flush || !stall_vec[0]) begin
                valid_d[0] = 1'b0;
                wen_d[0]   = 1'b0;
                waddr_d[0] = '0;
                data_d[0]  = '0;
            end
        end else if (!stall_vec[0]) begin
            valid_d[0] = 1'b1;
            wen_d[0]   = in_wen;
            waddr_d[0] = in_waddr;
            data_d[0]  = in_data;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (flush || (!stall_vec[k] && stall_vec[k-1])) begin
                valid_d[k] = 1'b0;
                wen_d[k]   = 1'b0;
                waddr_d[k] = '0;
                data_d[k]  = '0;
            end else if (!stall_vec[k]) begin
                valid_d[k] = valid_q[k-1];
                wen_d[k]   = wen_q[k-1];
                waddr_d[k] = waddr_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // Stall-cycle counter: clear beats increment, saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stall_vec[0] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Pipeline registers and counter; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            wen_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                waddr_q[k] <= '0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                waddr_q[k] <= waddr_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    // Flatten stage payloads onto the tap bus, R[0] in the low bits.
    always_comb begin
        stage_data = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign stall_o     = stall_vec;
    assign in_ready    = !stall_vec[0] && !flush;
    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign out_waddr   = waddr_q[STAGES-1];
    assign out_wen     = wen_q[STAGES-1] & valid_q[STAGES-1];
    assign stall_cnt   = cnt_q;

`ifdef PIPE_CHAIN_FWD_EN
    // Youngest matching writer wins: scan oldest to youngest, last hit sticks.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            if (valid_q[k] && wen_q[k] && (waddr_q[k] == lookup_addr) &&
                (lookup_addr != '0)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[k];
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_addr;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Testbench for pipe_chain (STAGES=5, WIDTH=32, AW=5, CW=4) with a
// stage-array reference model driven by the highest asserted stall index.
module tb_pipe_chain;
    localparam int STAGES  = 5;
    localparam int WIDTH   = 32;
    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_CHAIN_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic [AW-1:0]           in_waddr;
    logic                    in_wen;
    logic                    in_ready;
    logic [STAGES-1:0]       stall_req;
    logic                    flush;
    logic [STAGES-1:0]       stall_o;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [AW-1:0]           out_waddr;
    logic                    out_wen;
    logic [AW-1:0]           lookup_addr;
    logic                    lookup_hit;
    logic [WIDTH-1:0]        lookup_data;
    logic                    cnt_clr;
    logic [CW-1:0]           stall_cnt;

    always #5 clk = ~clk;

    pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_waddr(in_waddr), .in_wen(in_wen), .in_ready(in_ready),
        .stall_req(stall_req), .flush(flush), .stall_o(stall_o),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .out_valid(out_valid), .out_data(out_data), .out_waddr(out_waddr),
        .out_wen(out_wen), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one entry record per stage.
    logic [STAGES-1:0] m_valid;
    logic [STAGES-1:0] m_wen;
    logic [AW-1:0]     m_waddr [STAGES];
    logic [WIDTH-1:0]  m_data  [STAGES];
    int                m_cnt;
    bit                last_accept;
    int                next_val;
    int                exp_out;

    function automatic int top_stall(input logic [STAGES-1:0] req);
        int h;
        h = -1;
        for (int k = 0; k < STAGES; k++) if (req[k]) h = k;
        return h;
    endfunction

    function automatic logic [STAGES-1:0] exp_stall_o(input logic [STAGES-1:0] req);
        logic [STAGES-1:0] m;
        int h;
        m = '0;
        h = top_stall(req);
        for (int k = 0; k <= h; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [STAGES*WIDTH-1:0] exp_stage_data();
        logic [STAGES*WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < STAGES; k++) v[k*WIDTH +: WIDTH] = m_data[k];
        return v;
    endfunction

    function automatic logic [WIDTH:0] exp_lookup(input logic [AW-1:0] a);
        logic [WIDTH:0] r;
        r = '0;
        if (FWD && a != '0) begin
            for (int k = 0; k < STAGES; k++) begin
                if (m_valid[k] && m_wen[k] && m_waddr[k] == a) begin
                    r = {1'b1, m_data[k]};
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_wen   = '0;
        m_cnt   = 0;
        for (int k = 0; k < STAGES; k++) begin
            m_waddr[k] = '0;
            m_data[k]  = '0;
        end
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        int h;
        logic [STAGES-1:0] nv, nw;
        logic [AW-1:0]     na [STAGES];
        logic [WIDTH-1:0]  nd [STAGES];
        h = top_stall(stall_req);
        last_accept = in_valid && !flush && (h < 0);
        for (int k = 0; k < STAGES; k++) begin
            if (flush || (h >= 0 && k == h + 1)) begin
                nv[k] = 1'b0; nw[k] = 1'b0; na[k] = '0; nd[k] = '0;
            end else if (k <= h) begin
                nv[k] = m_valid[k]; nw[k] = m_wen[k]; na[k] = m_waddr[k]; nd[k] = m_data[k];
            end else if (k == 0) begin
                nv[0] = in_valid;
                nw[0] = in_valid & in_wen;
                na[0] = in_valid ? in_waddr : '0;
                nd[0] = in_valid ? in_data : '0;
            end else begin
                nv[k] = m_valid[k-1]; nw[k] = m_wen[k-1]; na[k] = m_waddr[k-1]; nd[k] = m_data[k-1];
            end
        end
        if (cnt_clr) m_cnt = 0;
        else if (h >= 0 && m_cnt < CNT_MAX) m_cnt++;
        @(posedge clk);
        m_valid = nv;
        m_wen   = nw;
        for (int k = 0; k < STAGES; k++) begin
            m_waddr[k] = na[k];
            m_data[k]  = nd[k];
        end
        #1;
    endtask

    task automatic stream_step();
        in_valid = 1'b1;
        in_data  = WIDTH'(next_val);
        in_waddr = AW'(next_val);
        in_wen   = 1'b1;
        step();
        if (last_accept) next_val++;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall_req = '0;
        in_valid = 1'b1; in_data = 32'h5A; in_waddr = 5'd3; in_wen = 1'b1; lookup_addr = 5'd3;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stage_valid !== '0) begin failures++; $display("FAIL reset_stage_valid got=%0h exp=0", stage_valid); end
        checks++; if (stage_data !== '0) begin failures++; $display("FAIL reset_stage_data got=%0h exp=0", stage_data); end
        checks++; if ({out_valid, out_wen, out_data, out_waddr} !== '0) begin failures++; $display("FAIL reset_out got v=%0b w=%0b d=%0h a=%0h exp=0", out_valid, out_wen, out_data, out_waddr); end
        checks++; if ({lookup_hit, lookup_data} !== '0) begin failures++; $display("FAIL reset_lookup got hit=%0b d=%0h exp=0", lookup_hit, lookup_data); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        rst = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        next_val = 1;
        exp_out  = 1;
        for (int e = 1; e <= 12; e++) begin
            stream_step();
            checks++; if (out_valid !== (e >= 5)) begin failures++; $display("FAIL stream_out_valid edge=%0d got=%0b exp=%0b", e, out_valid, (e >= 5)); end
            if (e >= 5) begin
                checks++; if (out_data !== WIDTH'(e - 4)) begin failures++; $display("FAIL stream_out_data edge=%0d got=%0d exp=%0d", e, out_data, e - 4); end
                exp_out = e - 3;
            end
        end
    endtask

    task automatic test_mid_stall();
        logic [WIDTH-1:0] held [3];
        cnt_clr = 1'b1;
        stream_step();
        cnt_clr = 1'b0;
        if (m_valid[STAGES-1]) exp_out++;
        for (int k = 0; k < 3; k++) held[k] = m_data[k];
        for (int c = 0; c < 2; c++) begin
            stall_req = 5'b00100;
            in_valid = 1'b1; in_data = WIDTH'(next_val);
            #1;
            checks++; if (stall_o !== 5'b00111) begin failures++; $display("FAIL mid_stall_o got=%b exp=00111", stall_o); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
            stream_step();
            checks++; if (stage_valid[3] !== 1'b0) begin failures++; $display("FAIL mid_bubble_r3 got=%b exp=0", stage_valid[3]); end
            checks++; if (stage_data[3*WIDTH-1:0] !== {held[2], held[1], held[0]}) begin failures++; $display("FAIL mid_hold got=%0h exp=%0h", stage_data[3*WIDTH-1:0], {held[2], held[1], held[0]}); end
            if (m_valid[STAGES-1]) begin
                checks++; if (out_data !== WIDTH'(exp_out)) begin failures++; $display("FAIL mid_out_seq got=%0d exp=%0d", out_data, exp_out); end
                exp_out++;
            end
        end
        checks++; if (stall_cnt !== CW'(2)) begin failures++; $display("FAIL mid_stall_cnt got=%0d exp=2", stall_cnt); end
        stall_req = '0;
        for (int c = 0; c < 8; c++) begin
            stream_step();
            checks++; if (out_valid !== m_valid[STAGES-1]) begin failures++; $display("FAIL mid_out_valid got=%b exp=%b", out_valid, m_valid[STAGES-1]); end
            if (m_valid[STAGES-1]) begin
                checks++; if (out_data !== WIDTH'(exp_out)) begin failures++; $display("FAIL mid_out_seq got=%0d exp=%0d", out_data, exp_out); end
                exp_out++;
            end
        end
    endtask

    task automatic test_competing_stalls();
        logic [4*WIDTH-1:0] held;
        held = {m_data[3], m_data[2], m_data[1], m_data[0]};
        stall_req = 5'b01010;
        in_valid = 1'b1; in_data = WIDTH'(next_val);
        #1;
        checks++; if (stall_o !== 5'b01111) begin failures++; $display("FAIL comp_stall_o got=%b exp=01111", stall_o); end
        stream_step();
        checks++; if (stage_valid !== 5'b01111) begin failures++; $display("FAIL comp_valid got=%b exp=01111", stage_valid); end
        checks++; if (stage_data[4*WIDTH-1:0] !== held) begin failures++; $display("FAIL comp_hold got=%0h exp=%0h", stage_data[4*WIDTH-1:0], held); end
        stall_req = '0;
        for (int c = 0; c < 3; c++) begin
            stream_step();
            if (m_valid[STAGES-1]) begin
                checks++; if (out_data !== WIDTH'(exp_out)) begin failures++; $display("FAIL comp_out_seq got=%0d exp=%0d", out_data, exp_out); end
                exp_out++;
            end
        end
    endtask

    task automatic test_flush_during_stall();
        stall_req = 5'b10000;
        flush = 1'b1;
        in_valid = 1'b1; in_data = WIDTH'(next_val);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        stream_step();
        checks++; if (stage_valid !== '0) begin failures++; $display("FAIL flush_valid got=%b exp=0", stage_valid); end
        checks++; if (out_wen !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_out got wen=%b v=%b exp=0", out_wen, out_valid); end
        flush = 1'b0; stall_req = '0; in_valid = 1'b0;
        step();
        checks++; if (stage_valid !== '0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", stage_valid); end
        exp_out = next_val;
    endtask

    task automatic test_forwarding();
        logic [AW-1:0]    fa [4];
        logic [WIDTH-1:0] fd [4];
        logic             fw [4];
        fa = '{5'd7, 5'd3, 5'd7, 5'd2};
        fd = '{32'hBB, 32'h11, 32'hAA, 32'h22};
        fw = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_waddr = fa[i]; in_data = fd[i]; in_wen = fw[i];
            step();
        end
        in_valid = 1'b0;
        stall_req = '1;
        checks++; if (stage_valid[3:0] !== 4'hF) begin failures++; $display("FAIL fwd_fill got=%b exp=1111", stage_valid[3:0]); end
        lookup_addr = 5'd7; #1;
        checks++; if ({lookup_hit, lookup_data} !== (FWD ? {1'b1, 32'hAA} : 33'h0)) begin failures++; $display("FAIL fwd_youngest got hit=%b d=%0h exp hit=%b", lookup_hit, lookup_data, FWD); end
        lookup_addr = 5'd3; #1;
        checks++; if ({lookup_hit, lookup_data} !== (FWD ? {1'b1, 32'h11} : 33'h0)) begin failures++; $display("FAIL fwd_addr3 got hit=%b d=%0h exp hit=%b", lookup_hit, lookup_data, FWD); end
        lookup_addr = 5'd2; #1;
        checks++; if ({lookup_hit, lookup_data} !== 33'h0) begin failures++; $display("FAIL fwd_no_wen got hit=%b d=%0h exp=0", lookup_hit, lookup_data); end
        lookup_addr = 5'd0; #1;
        checks++; if ({lookup_hit, lookup_data} !== 33'h0) begin failures++; $display("FAIL fwd_addr0 got hit=%b d=%0h exp=0", lookup_hit, lookup_data); end
        lookup_addr = 5'd9; #1;
        checks++; if ({lookup_hit, lookup_data} !== 33'h0) begin failures++; $display("FAIL fwd_miss got hit=%b d=%0h exp=0", lookup_hit, lookup_data); end
        stall_req = '0;
    endtask

    task automatic test_counter();
        cnt_clr = 1'b1; in_valid = 1'b0;
        step();
        cnt_clr = 1'b0;
        stall_req = 5'b00001;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 10) begin
                checks++; if (stall_cnt !== CW'(10)) begin failures++; $display("FAIL cnt_mid got=%0d exp=10", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== CW'(15)) begin failures++; $display("FAIL cnt_saturate got=%0d exp=15", stall_cnt); end
        cnt_clr = 1'b1;
        step();
        checks++; if (stall_cnt !== CW'(0)) begin failures++; $display("FAIL cnt_clr_wins got=%0d exp=0", stall_cnt); end
        cnt_clr = 1'b0;
        step();
        checks++; if (stall_cnt !== CW'(1)) begin failures++; $display("FAIL cnt_restart got=%0d exp=1", stall_cnt); end
        stall_req = '0;
    endtask

    task automatic test_random();
        logic [WIDTH:0] lk;
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = $urandom;
            in_waddr    = AW'($urandom_range(0, 7));
            in_wen      = ($urandom_range(0, 3) != 0);
            lookup_addr = AW'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 24) == 0);
            cnt_clr     = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < STAGES; k++) stall_req[k] = ($urandom_range(0, 9) == 0);
            #1;
            lk = exp_lookup(lookup_addr);
            checks++; if (stall_o !== exp_stall_o(stall_req)) begin failures++; $display("FAIL rnd_stall_o cyc=%0d got=%b exp=%b", c, stall_o, exp_stall_o(stall_req)); end
            checks++; if (in_ready !== (!flush && stall_req == '0)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b", c, in_ready); end
            checks++; if ({lookup_hit, lookup_data} !== lk) begin failures++; $display("FAIL rnd_lookup cyc=%0d got=%0h exp=%0h", c, {lookup_hit, lookup_data}, lk); end
            step();
            checks++; if (stage_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, stage_valid, m_valid); end
            checks++; if (stage_data !== exp_stage_data()) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", c, stage_data, exp_stage_data()); end
            checks++; if (out_wen !== (m_valid[STAGES-1] & m_wen[STAGES-1])) begin failures++; $display("FAIL rnd_out_wen cyc=%0d got=%b", c, out_wen); end
            if (m_valid[STAGES-1]) begin
                checks++; if (out_waddr !== m_waddr[STAGES-1]) begin failures++; $display("FAIL rnd_out_waddr cyc=%0d got=%0h exp=%0h", c, out_waddr, m_waddr[STAGES-1]); end
            end
            checks++; if (stall_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt); end
            if (c == 200) begin
                rst = 1'b0;
                #1;
                model_reset();
                checks++; if (stage_valid !== '0 || stall_cnt !== '0 || out_data !== '0) begin failures++; $display("FAIL rnd_async_reset got v=%b cnt=%0d d=%0h exp=0", stage_valid, stall_cnt, out_data); end
                #1;
                rst = 1'b1;
            end
        end
        flush = 1'b0; cnt_clr = 1'b0; stall_req = '0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mid_stall();
        test_competing_stalls();
        test_flush_during_stall();
        test_forwarding();
        test_counter();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
